// File: rtl/std_fifo_pkg.sv
// Shared helpers for std_fifo: ceiling log2 used to size pointers and the occupancy count.
// Pure elaboration-time function; no latency, no flow control.
package std_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i) + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/std_fifo_if.sv
// std_fifo bus bundle: master drives push/pop/d, slave returns q, count and status flags.
// No latency of its own; the slave ignores push when full and pop when empty.
interface std_fifo_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
);
  import std_fifo_pkg::*;

  logic                   push;
  logic                   pop;
  logic [WIDTH-1:0]       d;
  logic [WIDTH-1:0]       q;
  logic                   full;
  logic                   empty;
  logic [clog2(DEPTH):0]  count;
  logic                   almost_empty;
  logic                   almost_full;

  modport master (
    output push, pop, d,
    input  q, full, empty, count, almost_empty, almost_full
  );

  modport slave (
    input  push, pop, d,
    output q, full, empty, count, almost_empty, almost_full
  );
endinterface

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: one write port, one registered read port (block-RAM style).
// Read data appears the cycle after rd_en_i; holds otherwise; no flow control of its own.
module fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_dat_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_dat_q;

  // Array left unreset so it maps onto RAM primitives.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/std_fifo.sv
// Synchronous FIFO; q valid one cycle after pop; push dropped when full unless popping, pop ignored when empty.
// Define STD_FIFO_ERROR_CHECK_EN to print simulation ERROR messages on overflow/underflow attempts.
module std_fifo
  import std_fifo_pkg::*;
#(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned DEPTH              = 32,
  parameter int unsigned ALMOST_FULL_COUNT  = 16,
  parameter int unsigned ALMOST_EMPTY_COUNT = 1
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  almost_empty,
  output logic                  almost_full
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_COUNT);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_COUNT);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign count        = count_q;

  // A simultaneous pop frees the slot, so push while full is still accepted then.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i     (clk),
    .rst_n_i   (rst),
    .wr_en_i   (do_push && rst),
    .wr_addr_i (wr_ptr_q),
    .wr_dat_i  (d),
    .rd_en_i   (do_pop),
    .rd_addr_i (rd_ptr_q),
    .rd_dat_o  (q)
  );

`ifdef STD_FIFO_ERROR_CHECK_EN
  always @(posedge clk) begin
    if (rst && push && full && !pop)
      $display("ERROR: %m push while full, data dropped");
    if (rst && pop && empty)
      $display("ERROR: %m pop while empty, ignored");
  end
`endif

endmodule

// File: tb/tb_std_fifo.sv
// Directed bench for std_fifo at WIDTH=8, DEPTH=4, ALMOST_FULL_COUNT=2, ALMOST_EMPTY_COUNT=1.
module tb_std_fifo;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  std_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  std_fifo #(
    .WIDTH(8), .DEPTH(4), .ALMOST_FULL_COUNT(2), .ALMOST_EMPTY_COUNT(1)
  ) dut (
    .rst          (rst),
    .clk          (clk),
    .push         (bus.push),
    .pop          (bus.pop),
    .d            (bus.d),
    .q            (bus.q),
    .full         (bus.full),
    .empty        (bus.empty),
    .count        (bus.count),
    .almost_empty (bus.almost_empty),
    .almost_full  (bus.almost_full)
  );

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic ps, input logic pp, input logic [7:0] dd);
    bus.push = ps;
    bus.pop  = pp;
    bus.d    = dd;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(1'b1, 1'b1, 8'hAA);
    if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", bus.count); end n_checks++;
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", bus.empty); end n_checks++;
    if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", bus.full); end n_checks++;
    if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_ae got %b exp 1", bus.almost_empty); end n_checks++;
    if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_af got %b exp 0", bus.almost_full); end n_checks++;
    if (bus.q !== 8'h00) begin n_fail++; $display("FAIL rst_q got %h exp 00", bus.q); end n_checks++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_q;
    cyc(1'b1, 1'b0, 8'h11);
    if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL basic_ae1 got %b exp 1", bus.almost_empty); end n_checks++;
    cyc(1'b1, 1'b0, 8'h22);
    if (bus.almost_full !== 1'b1) begin n_fail++; $display("FAIL basic_af2 got %b exp 1", bus.almost_full); end n_checks++;
    cyc(1'b1, 1'b0, 8'h33);
    if (bus.count !== 3'd3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", bus.count); end n_checks++;
    if (bus.almost_empty !== 1'b0) begin n_fail++; $display("FAIL basic_ae3 got %b exp 0", bus.almost_empty); end n_checks++;
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      exp_q = 8'(i * 17);
      if (bus.q !== exp_q) begin n_fail++; $display("FAIL basic_q%0d got %h exp %h", i, bus.q, exp_q); end n_checks++;
    end
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b exp 1", bus.empty); end n_checks++;
  endtask

  task automatic test_full();
    logic [7:0] exp_q;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 8'(i));
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", bus.full); end n_checks++;
    cyc(1'b1, 1'b0, 8'h55);
    if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", bus.count); end n_checks++;
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_flag2 got %b exp 1", bus.full); end n_checks++;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      exp_q = 8'(i);
      if (bus.q !== exp_q) begin n_fail++; $display("FAIL full_q%0d got %h exp %h", i, bus.q, exp_q); end n_checks++;
    end
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL full_drained got %b exp 1", bus.empty); end n_checks++;
  endtask

  task automatic test_pop_empty();
    cyc(1'b0, 1'b1, 8'h00);
    if (bus.q !== 8'h04) begin n_fail++; $display("FAIL pe_q got %h exp 04", bus.q); end n_checks++;
    if (bus.count !== 3'd0) begin n_fail++; $display("FAIL pe_count got %0d exp 0", bus.count); end n_checks++;
    cyc(1'b1, 1'b1, 8'h66);
    if (bus.count !== 3'd1) begin n_fail++; $display("FAIL pe_pp_count got %0d exp 1", bus.count); end n_checks++;
    if (bus.q !== 8'h04) begin n_fail++; $display("FAIL pe_pp_q got %h exp 04", bus.q); end n_checks++;
    cyc(1'b0, 1'b1, 8'h00);
    if (bus.q !== 8'h66) begin n_fail++; $display("FAIL pe_after_q got %h exp 66", bus.q); end n_checks++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q;
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
    cyc(1'b1, 1'b1, 8'hA5);
    if (bus.q !== 8'hA1) begin n_fail++; $display("FAIL fpp_q got %h exp a1", bus.q); end n_checks++;
    if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fpp_count got %0d exp 4", bus.count); end n_checks++;
    for (int i = 2; i <= 5; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      exp_q = 8'(8'hA0 + i);
      if (bus.q !== exp_q) begin n_fail++; $display("FAIL fpp_q%0d got %h exp %h", i, bus.q, exp_q); end n_checks++;
    end
  endtask

  task automatic test_almost_full();
    logic [7:0] exp_q;
    cyc(1'b1, 1'b0, 8'h10);
    cyc(1'b1, 1'b0, 8'h20);
    if (bus.almost_full !== 1'b1) begin n_fail++; $display("FAIL af_flag got %b exp 1", bus.almost_full); end n_checks++;
    for (int i = 3; i <= 5; i++) begin
      cyc(1'b1, 1'b1, 8'(i * 16));
      exp_q = 8'((i - 2) * 16);
      if (bus.q !== exp_q) begin n_fail++; $display("FAIL af_q%0d got %h exp %h", i, bus.q, exp_q); end n_checks++;
      if (bus.count !== 3'd2) begin n_fail++; $display("FAIL af_count%0d got %0d exp 2", i, bus.count); end n_checks++;
    end
    for (int i = 4; i <= 5; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      exp_q = 8'(i * 16);
      if (bus.q !== exp_q) begin n_fail++; $display("FAIL af_drain%0d got %h exp %h", i, bus.q, exp_q); end n_checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    cyc(1'b1, 1'b0, 8'hC0);
    for (int i = 1; i < 10; i++) begin
      cyc(1'b1, 1'b1, 8'(8'hC0 + i));
      exp_q = 8'(8'hC0 + i - 1);
      if (bus.q !== exp_q) begin n_fail++; $display("FAIL b2b_q%0d got %h exp %h", i, bus.q, exp_q); end n_checks++;
      if (bus.count !== 3'd1) begin n_fail++; $display("FAIL b2b_count%0d got %0d exp 1", i, bus.count); end n_checks++;
    end
    cyc(1'b0, 1'b1, 8'h00);
    if (bus.q !== 8'hC9) begin n_fail++; $display("FAIL b2b_last got %h exp c9", bus.q); end n_checks++;
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b exp 1", bus.empty); end n_checks++;
  endtask

  initial begin
    rst      = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.d    = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_pop_empty();
    test_full_push_pop();
    test_almost_full();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/std_fifo.md
STD_FIFO -- requirements
Module: std_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries; power of two, at least 2.
REQ-003 SHALL have parameter ALMOST_FULL_COUNT, default 16: almost_full threshold.
REQ-004 SHALL have parameter ALMOST_EMPTY_COUNT, default 1: almost_empty threshold.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 SHALL order ports positionally as: rst, clk, push, pop, d, q, full, empty, count, almost_empty, almost_full.
REQ-007 rst  input  1  synchronous active-low reset.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 push  input  1  write d this cycle.
REQ-010 pop  input  1  read oldest entry this cycle.
REQ-011 d  input  WIDTH  write data.
REQ-012 q  output  WIDTH  registered read data.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 count  output  log2(DEPTH)+1  occupancy, 0..DEPTH; also readable hierarchically as instance.count.
REQ-016 almost_empty  output  1  count <= ALMOST_EMPTY_COUNT.
REQ-017 almost_full  output  1  count >= ALMOST_FULL_COUNT.

Function
REQ-018 SHALL be a first-in first-out buffer with a circular write pointer and a circular read pointer, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-019 SHALL decode full, empty, almost_empty and almost_full combinationally from the count register, so callers can gate pop on !empty in the same cycle.
REQ-020 Accepted push SHALL write d at the write pointer and advance it on the same clock edge.
REQ-021 Accepted pop SHALL load q with the entry at the read pointer on that edge, so q is valid the cycle after pop; q holds its value otherwise.
REQ-022 pop while empty SHALL be ignored: q, pointers and count unchanged.
REQ-023 push while full without pop SHALL be ignored: data dropped, state unchanged.
REQ-024 push and pop together while full SHALL both be accepted; count stays DEPTH.
REQ-025 push and pop together while empty SHALL accept only the push; count becomes 1 and q is unchanged.
REQ-026 push and pop together otherwise SHALL both be accepted; count unchanged, order preserved.
REQ-027 count SHALL be +1 on push-only, -1 on pop-only, and never leave 0..DEPTH.

Reset
REQ-028 With rst low at a rising edge, SHALL clear pointers, count and q to 0, giving empty=1, almost_empty=1, full=0, almost_full=0 (ALMOST_FULL_COUNT>0).
REQ-029 Reset SHALL override push and pop in the same cycle; memory contents need not be cleared.

Configuration
REQ-030 Macro STD_FIFO_ERROR_CHECK_EN defined: simulation-only checks, excluded from synthesis, SHALL print a message containing "ERROR" on push while full without pop and on pop while empty.
REQ-031 Macro STD_FIFO_ERROR_CHECK_EN undefined: no checks compiled; RTL behaviour identical in both cases.

Structure
REQ-032 The log2 ceiling function used for pointer and count widths SHALL live in the shared common package/include, not in this module.
REQ-033 Storage SHALL be a sub-module fifo_mem with one write port and one registered read port, WIDTH x DEPTH, inferable as block RAM.

Verification (WIDTH=8, DEPTH=4, ALMOST_FULL_COUNT=2, ALMOST_EMPTY_COUNT=1)
REQ-034 Hold rst low one cycle -> count=0, empty=1, full=0, almost_empty=1, almost_full=0, q=0x00.
REQ-035 Push 0x11,0x22,0x33, then pop three times -> q=0x11,0x22,0x33 one cycle after each pop; empty=1 after the third pop.
REQ-036 Push 0x01..0x04, then push 0x55 -> full=1, count=4, 0x55 dropped; four pops return 0x01..0x04.
REQ-037 Pop while empty -> q, count=0 unchanged; with STD_FIFO_ERROR_CHECK_EN, an ERROR message is printed.
REQ-038 At count=2 (almost_full=1), push+pop for 3 cycles -> count stays 2, outputs in push order.
REQ-039 Stream 10 values with push and pop every cycle after the first push -> all 10 out in order across pointer wrap; count never exceeds 1.
